fifo_ep_sched: RTL and testbench
================================

// Module: fifo_ep_sched
// PURPOSE
//  Master-mode endpoint scheduler for the FT600 FIFO datapath. Picks one endpoint by round-robin
//  among eligible endpoints and drives the shared ep_num/m_wr_sel/m_wr_en/m_rd_en bus for one burst.
//  Sits between the bus-side handshake and the per-endpoint pointer blocks.
//  Master write (m_wr_en) drains an IN endpoint to the bus; master read (m_rd_en) fills an OUT endpoint.
// PARAMETERS
//  N_EP       4        number of endpoints (1..7); endpoint numbers 0..N_EP-1
//  EP_NW      3        ep_num width; N_EP < 2**EP_NW
//  EP_DIR     4'b0011  per-EP direction, bit i=1: master write (IN), 0: master read (OUT)
//  MAX_BURST  256      max words per grant (>=1)
//  PTR_W      12       endpoint read-pointer width incl. roll-over bit
// PORTS
//  fifoClk       in   1          clock
//  fifoRstn      in   1          async active-low reset
//  i_mode        in   1          1 = scheduling disabled (sampled in IDLE only)
//  bus_ready     in   1          bus accepts/provides a word this cycle
//  bus_abort     in   1          bus terminated transfer, data of burst discarded
//  ep_empty      in   N_EP       per-EP internal FIFO empty
//  ep_full       in   N_EP       per-EP internal FIFO full
//  ep_rd_ptr     in   PTR_W      OR of all EP read pointers (non-selected EPs drive 0)
//  ep_num        out  EP_NW      selected endpoint; EP_IDLE when none
//  m_wr_sel      out  1          1 = read-address selected (IN burst)
//  m_wr_en       out  1          master write strobe
//  m_rd_en       out  1          master read strobe
//  u_rd_ptr      out  1          load c_rd_ptr into selected EP read pointer
//  c_rd_ptr      out  PTR_W      pointer value for u_rd_ptr
//  busy          out  1          state != IDLE
//  burst_done    out  1          1-cycle pulse on leaving END
// BEHAVIOUR
//  Reset: state IDLE, ep_num=EP_IDLE (all ones), all strobes 0, c_rd_ptr=0, busy=0, rr pointer=0.
//  elig[i] = EP_DIR[i] ? ~ep_empty[i] : ~ep_full[i].
//  IDLE: if ~i_mode & |elig -> ARB.
//  ARB: grant first eligible index after last grant (wrap at N_EP); register ep_num, m_wr_sel=EP_DIR[g];
//   rr pointer <= g; clear word counter -> SETUP. No eligible (dropped) -> IDLE.
//  SETUP: 1 cycle for ram_adr settle; capture ckpt <= ep_rd_ptr -> XFER.
//  XFER: m_wr_en = m_wr_sel & bus_ready & ~ep_empty[g]; m_rd_en = ~m_wr_sel & bus_ready & ~ep_full[g]
//   (combinational from registered state, ep_num). Counter += strobe.
//   Exit -> END when: bus_abort; or counter==MAX_BURST-1 with a strobe; or strobe blocked by empty/full;
//   or bus_ready low after >=1 word. Last strobe occurs in the exit cycle.
//  END: strobes 0, ep_num held; next cycle ep_num=EP_IDLE, burst_done=1, -> IDLE.
//  Bus idle-to-strobe latency: 3 cycles from eligible (ARB, SETUP, XFER).
//  bus_abort and end condition same cycle: abort wins. Counter never wraps; width clog2(MAX_BURST+1).
//  Reset mid-burst: immediate return to reset values; endpoint pointers not rolled back.
//  m_wr_en and m_rd_en never both 1; u_rd_ptr never together with a strobe.
// CONFIGURATION
//  FT_SCHED_ROLLBACK_EN defined: bus_abort in XFER of an IN burst -> ROLLBACK state (1 cycle):
//   c_rd_ptr=ckpt, u_rd_ptr=1, ep_num held -> END. OUT bursts: abort -> END, no rollback.
//  Undefined: no ROLLBACK state; u_rd_ptr and c_rd_ptr tied 0; abort = normal termination.
// STRUCTURE
//  pkg_ft601_ctrl_defines: typedef enum sched_state_t {IDLE,ARB,SETUP,XFER,ROLLBACK,END}; EP_IDLE constant.
//  Sub-module fifo_rr_arb: N-way round-robin, inputs req/last, output grant index + valid (combinational).
// TESTING
//  1 Reset with all ep_empty=1, ep_full=0, EP_DIR=0011 -> grant EP2 first (OUT); ep_num=2,
//    m_rd_en follows bus_ready after 3 cycles.
//  2 EP0,EP1 non-empty, EP2,EP3 full -> grants alternate 0,1,0,1; ep_num=7 between bursts.
//  3 EP0 holds 300 words, bus_ready=1 -> burst of exactly 256 m_wr_en, burst_done, next grant EP1.
//  4 EP1 holds 5 words -> 5 strobes, stops on ep_empty, no 6th strobe.
//  5 ROLLBACK_EN, ckpt=0x040, abort after 10 words -> u_rd_ptr=1 one cycle, c_rd_ptr=0x040.
//    Without the macro: u_rd_ptr stays 0.
//  6 i_mode=1 in IDLE -> no grant; fifoRstn low in XFER -> strobes 0 and ep_num=7 asynchronously.

Source files
------------

// File: rtl/pkg_ft601_ctrl_defines.sv
// rtl/pkg_ft601_ctrl_defines.sv - shared types and constants for the FT600 endpoint scheduler
package pkg_ft601_ctrl_defines;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SETUP,
    XFER,
    ROLLBACK,
    END
  } sched_state_t;

  // Wide enough for any ep_num width in use; truncated to EP_NW at the point of use.
  localparam logic [7:0] EP_IDLE = 8'hFF;

endpackage

// File: rtl/fifo_rr_arb.sv
// rtl/fifo_rr_arb.sv - combinational N-way round-robin arbiter, search starts after i_last
module fifo_rr_arb #(
  parameter int N_EP  = 4,
  parameter int EP_NW = 3
) (
  input  logic [N_EP-1:0]  i_req,
  input  logic [EP_NW-1:0] i_last,
  output logic [EP_NW-1:0] o_grant,
  output logic             o_valid
);

  // Walk offsets from farthest to nearest so the nearest requester after i_last is written last.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = N_EP; k >= 1; k--) begin
      for (int i = 0; i < N_EP; i++) begin
        if (i_req[i] && (i == (int'(i_last) + k) % N_EP)) begin
          o_grant = EP_NW'(i);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_ep_sched.sv
// rtl/fifo_ep_sched.sv - master-mode round-robin endpoint burst scheduler for the FT600 datapath
// Optional read-pointer rollback on aborted IN bursts: define FT_SCHED_ROLLBACK_EN.
module fifo_ep_sched
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int              N_EP      = 4,
  parameter int              EP_NW     = 3,
  parameter logic [N_EP-1:0] EP_DIR    = N_EP'(4'b0011),
  parameter int              MAX_BURST = 256,
  parameter int              PTR_W     = 12
) (
  input  logic              fifoClk,
  input  logic              fifoRstn,
  input  logic              i_mode,
  input  logic              bus_ready,
  input  logic              bus_abort,
  input  logic [N_EP-1:0]   ep_empty,
  input  logic [N_EP-1:0]   ep_full,
  input  logic [PTR_W-1:0]  ep_rd_ptr,
  output logic [EP_NW-1:0]  ep_num,
  output logic              m_wr_sel,
  output logic              m_wr_en,
  output logic              m_rd_en,
  output logic              u_rd_ptr,
  output logic [PTR_W-1:0]  c_rd_ptr,
  output logic              busy,
  output logic              burst_done
);

  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [EP_NW-1:0] EP_IDLE_N = EP_NW'(EP_IDLE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  sched_state_t     w_abort_state;
  logic [EP_NW-1:0] r_ep_num;
  logic [EP_NW-1:0] r_rr;
  logic             r_wr_sel;
  logic             r_burst_done;
  logic [CNT_W-1:0] r_cnt;

  logic [N_EP-1:0]  w_elig;
  logic [EP_NW-1:0] w_grant;
  logic             w_grant_vld;
  logic             w_grant_dir;
  logic             w_sel_empty;
  logic             w_sel_full;
  logic             w_in_xfer;
  logic             w_strobe;
  logic             w_blocked;
  logic             w_xfer_end;

  assign w_elig = (EP_DIR & ~ep_empty) | (~EP_DIR & ~ep_full);

  fifo_rr_arb #(
    .N_EP  (N_EP),
    .EP_NW (EP_NW)
  ) u_rr_arb (
    .i_req   (w_elig),
    .i_last  (r_rr),
    .o_grant (w_grant),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    w_sel_empty = 1'b0;
    w_sel_full  = 1'b0;
    w_grant_dir = 1'b0;
    for (int i = 0; i < N_EP; i++) begin
      if (r_ep_num == EP_NW'(i)) begin
        w_sel_empty = ep_empty[i];
        w_sel_full  = ep_full[i];
      end
      if (w_grant == EP_NW'(i)) begin
        w_grant_dir = EP_DIR[i];
      end
    end
  end

  // Strobes are combinational so the word that ends a burst is still transferred in the exit cycle.
  assign w_in_xfer = (r_state == XFER);
  assign m_wr_en   = w_in_xfer &  r_wr_sel & bus_ready & ~w_sel_empty;
  assign m_rd_en   = w_in_xfer & ~r_wr_sel & bus_ready & ~w_sel_full;
  assign w_strobe  = m_wr_en | m_rd_en;
  assign w_blocked = bus_ready & (r_wr_sel ? w_sel_empty : w_sel_full);
  assign w_xfer_end = (w_strobe && (r_cnt == CNT_LAST)) || w_blocked ||
                      (!bus_ready && (r_cnt != '0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (!i_mode && (|w_elig)) w_state_nxt = ARB;
      ARB:      w_state_nxt = w_grant_vld ? SETUP : IDLE;
      SETUP:    w_state_nxt = XFER;
      XFER: begin
        if (bus_abort)       w_state_nxt = w_abort_state;
        else if (w_xfer_end) w_state_nxt = END;
      end
      ROLLBACK: w_state_nxt = END;
      END:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      r_state      <= IDLE;
      r_ep_num     <= EP_IDLE_N;
      r_rr         <= '0;
      r_wr_sel     <= 1'b0;
      r_cnt        <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_done <= (r_state == END);
      case (r_state)
        ARB: begin
          r_cnt <= '0;
          if (w_grant_vld) begin
            r_ep_num <= w_grant;
            r_wr_sel <= w_grant_dir;
            r_rr     <= w_grant;
          end
        end
        XFER:    r_cnt    <= r_cnt + CNT_W'(w_strobe);
        END:     r_ep_num <= EP_IDLE_N;
        default: ;
      endcase
    end
  end

`ifdef FT_SCHED_ROLLBACK_EN
  logic [PTR_W-1:0] r_ckpt;

  // The pointer seen in SETUP is where the burst starts, so an abort rewinds to it.
  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      r_ckpt <= '0;
    end else if (r_state == SETUP) begin
      r_ckpt <= ep_rd_ptr;
    end
  end

  assign w_abort_state = r_wr_sel ? ROLLBACK : END;
  assign u_rd_ptr      = (r_state == ROLLBACK);
  assign c_rd_ptr      = u_rd_ptr ? r_ckpt : '0;
`else
  logic w_unused_rd_ptr;

  assign w_unused_rd_ptr = ^ep_rd_ptr;
  assign w_abort_state   = END;
  assign u_rd_ptr        = 1'b0;
  assign c_rd_ptr        = '0;
`endif

  assign ep_num     = r_ep_num;
  assign m_wr_sel   = r_wr_sel;
  assign busy       = (r_state != IDLE);
  assign burst_done = r_burst_done;

endmodule

// File: tb/tb_fifo_ep_sched.sv
// tb/tb_fifo_ep_sched.sv - scoreboard bench: endpoint FIFO model, burst-level reference, monitor
module tb_fifo_ep_sched;

  localparam int         N_EP = 4;
  localparam logic [3:0] DIR  = 4'b0011;
  localparam int         MAXB = 256;
`ifdef FT_SCHED_ROLLBACK_EN
  localparam int         RB   = 1;
`else
  localparam int         RB   = 0;
`endif

  logic        fifoClk   = 1'b0;
  logic        fifoRstn  = 1'b0;
  logic        i_mode    = 1'b0;
  logic        bus_ready = 1'b0;
  logic        bus_abort = 1'b0;
  logic [3:0]  ep_empty  = 4'hF;
  logic [3:0]  ep_full   = 4'hF;
  logic [11:0] ep_rd_ptr = 12'h000;
  logic [2:0]  ep_num;
  logic        m_wr_sel, m_wr_en, m_rd_en, u_rd_ptr, busy, burst_done;
  logic [11:0] c_rd_ptr;

  fifo_ep_sched #(
    .N_EP(N_EP), .EP_NW(3), .EP_DIR(DIR), .MAX_BURST(MAXB), .PTR_W(12)
  ) dut (
    .fifoClk(fifoClk), .fifoRstn(fifoRstn), .i_mode(i_mode),
    .bus_ready(bus_ready), .bus_abort(bus_abort),
    .ep_empty(ep_empty), .ep_full(ep_full), .ep_rd_ptr(ep_rd_ptr),
    .ep_num(ep_num), .m_wr_sel(m_wr_sel), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .u_rd_ptr(u_rd_ptr), .c_rd_ptr(c_rd_ptr), .busy(busy), .burst_done(burst_done)
  );

  always #5 fifoClk = ~fifoClk;

  typedef struct {
    int ep;
    int len;
    int rb;
    int ckpt;
  } burst_t;

  burst_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     cnt[4] = '{0, 0, 0, 0};
  int     model_last = 0;
  int     env_words = 0;
  int     abort_after = 0;
  bit     rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ep, input int len, input int rb, input int ckpt);
    burst_t e;
    e.ep = ep; e.len = len; e.rb = rb; e.ckpt = ckpt;
    exp_q.push_back(e);
  endtask

  // Reference: repeatedly grant the first endpoint after the last grant that can move data,
  // and move min(available, MAXB) words in that grant.
  task automatic plan();
    int av[4];
    int g, len;
    av = cnt;
    for (int guard = 0; guard < 64; guard++) begin
      g = -1;
      for (int k = 1; k <= N_EP; k++)
        if (g < 0 && av[(model_last + k) % N_EP] > 0) g = (model_last + k) % N_EP;
      if (g < 0) break;
      len = (av[g] < MAXB) ? av[g] : MAXB;
      av[g] -= len;
      push_exp(g, len, 0, 0);
      model_last = g;
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge fifoClk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_idle_ep"}, ep_num, 7);
    repeat (2) @(negedge fifoClk);
  endtask

  // Endpoint FIFO model: IN endpoints hold words, OUT endpoints hold free space.
  initial begin : env
    int s_wr, s_rd, s_rb, s_ep, s_busy;
    s_wr = 0; s_rd = 0; s_rb = 0; s_ep = 7; s_busy = 0;
    forever begin
      @(posedge fifoClk);
      #1;
      if (s_busy == 0) env_words = 0;
      if ((s_wr != 0 || s_rd != 0) && s_ep < N_EP) begin
        if (cnt[s_ep] > 0) cnt[s_ep]--;
        env_words++;
      end
      if (s_rb != 0 && s_ep < N_EP) cnt[s_ep] += env_words;
      bus_abort = 1'b0;
      if (abort_after > 0 && env_words == abort_after) begin
        bus_ready   = 1'b0;
        bus_abort   = 1'b1;
        abort_after = 0;
      end else if (rand_ready && env_words == 0) begin
        bus_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus_ready = 1'b1;
      end
      for (int i = 0; i < N_EP; i++) begin
        ep_empty[i] = DIR[i] ? (cnt[i] == 0) : 1'b1;
        ep_full[i]  = DIR[i] ? 1'b0 : (cnt[i] == 0);
      end
      @(negedge fifoClk);
      s_wr = m_wr_en; s_rd = m_rd_en; s_rb = u_rd_ptr; s_ep = ep_num; s_busy = busy;
    end
  end

  initial begin : mon
    int m_len, m_rb, m_ep, m_wr;
    burst_t e;
    m_len = 0; m_rb = 0; m_ep = -1; m_wr = 0;
    forever begin
      @(negedge fifoClk);
      if (!fifoRstn) begin
        m_len = 0; m_rb = 0; m_ep = -1;
      end else begin
        if (m_wr_en || m_rd_en) begin
          if (m_len == 0) begin
            m_ep = ep_num;
            m_wr = m_wr_en;
          end
          chk("strobe_excl", m_wr_en & m_rd_en, 0);
          chk("urd_with_strobe", u_rd_ptr, 0);
          m_len++;
        end
        if (u_rd_ptr) begin
          m_rb++;
          chk("c_rd_ptr", c_rd_ptr, (exp_q.size() > 0) ? exp_q[0].ckpt : -1);
        end
        if (burst_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_burst", m_ep, -1);
          end else begin
            e = exp_q.pop_front();
            chk("burst_ep", m_ep, e.ep);
            chk("burst_len", m_len, e.len);
            chk("burst_dir", m_wr, int'(DIR[e.ep]));
            chk("rollback_pulses", m_rb, e.rb);
            chk("ep_idle_after", ep_num, 7);
          end
          m_len = 0; m_rb = 0; m_ep = -1;
        end
      end
    end
  end

  initial begin : main
    int n, seen;
    // Reset state and first-grant latency: only OUT endpoints can move data.
    cnt = '{0, 0, 4, 3};
    repeat (3) @(negedge fifoClk);
    chk("rst_ep_num", ep_num, 7);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", m_wr_en, 0);
    chk("rst_rd_en", m_rd_en, 0);
    chk("rst_u_rd_ptr", u_rd_ptr, 0);
    chk("rst_c_rd_ptr", c_rd_ptr, 0);
    chk("rst_burst_done", burst_done, 0);
    model_last = 0;
    plan();
    fifoRstn = 1'b1;
    @(negedge fifoClk);
    chk("lat_cycle1_rd_en", m_rd_en, 0);
    @(negedge fifoClk);
    chk("lat_setup_ep_num", ep_num, 2);
    chk("lat_cycle2_rd_en", m_rd_en, 0);
    @(negedge fifoClk);
    chk("lat_cycle3_rd_en", m_rd_en, 1);
    chk("lat_wr_sel", m_wr_sel, 0);
    drain(500, "out_pair");

    // Two IN endpoints with more than one max burst each: 0,1,0,1 with 256-word first bursts.
    cnt = '{300, 300, 0, 0};
    plan();
    drain(3000, "alternate");

    // Scheduling disabled holds off a pending endpoint; releasing it gives a short 5-word burst.
    i_mode = 1'b1;
    cnt = '{0, 5, 0, 0};
    seen = 0;
    repeat (20) begin
      @(negedge fifoClk);
      seen |= int'(m_wr_en | m_rd_en | busy);
    end
    chk("mode_hold_activity", seen, 0);
    chk("mode_hold_ep_num", ep_num, 7);
    plan();
    i_mode = 1'b0;
    drain(200, "short_burst");

    // Abort of an IN burst after 10 words with checkpoint 0x040.
    ep_rd_ptr = 12'h040;
    abort_after = 10;
    cnt = '{20, 0, 0, 0};
    push_exp(0, 10, RB, 12'h040);
    push_exp(0, (RB != 0) ? 20 : 10, 0, 0);
    model_last = 0;
    drain(400, "abort");
    ep_rd_ptr = 12'h000;

    // Random endpoint fill levels with random bus stalls before the first word.
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_EP; i++)
        cnt[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
      plan();
      drain(5000, "random");
    end
    rand_ready = 1'b0;

    // Reset in the middle of a burst clears outputs without waiting for a clock edge.
    cnt = '{200, 0, 0, 0};
    n = 0;
    while (env_words < 8 && n < 100) begin
      @(negedge fifoClk);
      n++;
    end
    chk("midburst_reached", int'(env_words >= 8), 1);
    @(posedge fifoClk);
    #2;
    fifoRstn = 1'b0;
    #1;
    chk("async_rst_wr_en", m_wr_en, 0);
    chk("async_rst_rd_en", m_rd_en, 0);
    chk("async_rst_ep_num", ep_num, 7);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge fifoClk);
    model_last = 0;
    plan();
    fifoRstn = 1'b1;
    drain(600, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
